// File: rtl/apu_mixer_sample.sv
// APU output mixer: snapshots channel amplitudes and NR50/NR51 controls once per
// sample period, serially sums the routed terms per side, scales each side by
// (volume+1) with a shift-add and presents 10-bit left/right samples with a
// one-clock valid strobe.
//
// state | meaning
// IDLE  | waiting for the sample tick; snapshot taken on the tick
// ACC   | 5 clocks, idx 0..4: add ch1..ch4 then VIN into sum_l/sum_r
// MUL   | 3 clocks, idx 0..2: prod += sum<<idx for each set volume bit
// DONE  | 1 clock: publish prod_l/prod_r and pulse sample_valid
module apu_mixer_sample #(
  parameter int unsigned SAMPLE_DIV = 16
) (
  input  logic       apuv_4mhz,
  input  logic       napu_reset,
  input  logic       apu_ena,
  input  logic [3:0] ch1_amp,
  input  logic [3:0] ch2_amp,
  input  logic [3:0] ch3_amp,
  input  logic [3:0] ch4_amp,
  input  logic [3:0] ch_dac_en,
  input  logic [3:0] vin,
  input  logic [3:0] rmixer,
  input  logic [3:0] lmixer,
  input  logic [2:0] nrvolume,
  input  logic [2:0] nlvolume,
  input  logic       vin_r_ena,
  input  logic       vin_l_ena,
  output logic [9:0] lout,
  output logic [9:0] rout,
  output logic       sample_valid,
  output logic       busy,
  output logic       overrun
);

  localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  typedef enum logic [1:0] {IDLE, ACC, MUL, DONE} state_t;

  state_t           state, next_state;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [2:0]       idx;

  // snapshot registers
  logic [3:0] amp_q [4];
  logic [3:0] dac_q, vin_q, lmix_q, rmix_q;
  logic [2:0] vol_l_q, vol_r_q;
  logic       vin_l_q, vin_r_q;

  logic [6:0] sum_l, sum_r, sum_l_nxt, sum_r_nxt;
  logic [9:0] prod_l, prod_r, mul_l_add, mul_r_add;
  logic [3:0] term;
  logic       route_l, route_r, vol_l_bit, vol_r_bit;

  logic snap, acc_step, mul_step, fire, ovf_set;

  assign tick = apu_ena && (div_cnt == DIV_LAST);
  assign busy = (state != IDLE);

  // state register
  always_ff @(posedge apuv_4mhz or negedge napu_reset) begin
    if (!napu_reset) state <= IDLE;
    else             state <= next_state;
  end

  // next-state and step controls; disable forces IDLE and drops the current op
  always_comb begin
    next_state = state;
    snap       = 1'b0;
    acc_step   = 1'b0;
    mul_step   = 1'b0;
    fire       = 1'b0;
    ovf_set    = tick && (state != IDLE);
    case (state)
      IDLE: if (tick) begin
        snap       = 1'b1;
        next_state = ACC;
      end
      ACC: begin
        acc_step = 1'b1;
        if (idx == 3'd4) next_state = MUL;
      end
      MUL: begin
        mul_step = 1'b1;
        if (idx == 3'd2) next_state = DONE;
      end
      DONE: begin
        fire       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (!apu_ena) begin
      next_state = IDLE;
      snap       = 1'b0;
      acc_step   = 1'b0;
      mul_step   = 1'b0;
      fire       = 1'b0;
    end
  end

  // select the term for this ACC step and the volume bit for this MUL step
  always_comb begin
    term      = 4'd0;
    route_l   = 1'b0;
    route_r   = 1'b0;
    vol_l_bit = 1'b0;
    vol_r_bit = 1'b0;
    if (idx == 3'd4) begin
      term    = vin_q;
      route_l = vin_l_q;
      route_r = vin_r_q;
    end else begin
      term    = amp_q[idx[1:0]];
      route_l = lmix_q[idx[1:0]] & dac_q[idx[1:0]];
      route_r = rmix_q[idx[1:0]] & dac_q[idx[1:0]];
    end
    case (idx)
      3'd0: begin vol_l_bit = vol_l_q[0]; vol_r_bit = vol_r_q[0]; end
      3'd1: begin vol_l_bit = vol_l_q[1]; vol_r_bit = vol_r_q[1]; end
      3'd2: begin vol_l_bit = vol_l_q[2]; vol_r_bit = vol_r_q[2]; end
      default: begin vol_l_bit = 1'b0; vol_r_bit = 1'b0; end
    endcase
    sum_l_nxt = sum_l + (route_l ? {3'b000, term} : 7'd0);
    sum_r_nxt = sum_r + (route_r ? {3'b000, term} : 7'd0);
    mul_l_add = vol_l_bit ? ({3'b000, sum_l} << idx) : 10'd0;
    mul_r_add = vol_r_bit ? ({3'b000, sum_r} << idx) : 10'd0;
  end

  // sticky overrun flag; survives apu_ena going low
  always_ff @(posedge apuv_4mhz or negedge napu_reset) begin
    if (!napu_reset)  overrun <= 1'b0;
    else if (ovf_set) overrun <= 1'b1;
  end

  // sample divider, snapshot, accumulate/multiply datapath and output registers
  always_ff @(posedge apuv_4mhz or negedge napu_reset) begin
    if (!napu_reset) begin
      div_cnt      <= '0;
      idx          <= 3'd0;
      for (int i = 0; i < 4; i++) amp_q[i] <= 4'd0;
      dac_q        <= 4'd0;
      vin_q        <= 4'd0;
      lmix_q       <= 4'd0;
      rmix_q       <= 4'd0;
      vol_l_q      <= 3'd0;
      vol_r_q      <= 3'd0;
      vin_l_q      <= 1'b0;
      vin_r_q      <= 1'b0;
      sum_l        <= 7'd0;
      sum_r        <= 7'd0;
      prod_l       <= 10'd0;
      prod_r       <= 10'd0;
      lout         <= 10'd0;
      rout         <= 10'd0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (!apu_ena) begin
        div_cnt <= '0;
        lout    <= 10'd0;
        rout    <= 10'd0;
      end else begin
        div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
        if (snap) begin
          amp_q[0] <= ch1_amp;
          amp_q[1] <= ch2_amp;
          amp_q[2] <= ch3_amp;
          amp_q[3] <= ch4_amp;
          dac_q    <= ch_dac_en;
          vin_q    <= vin;
          lmix_q   <= lmixer;
          rmix_q   <= rmixer;
          vol_l_q  <= ~nlvolume;
          vol_r_q  <= ~nrvolume;
          vin_l_q  <= vin_l_ena;
          vin_r_q  <= vin_r_ena;
          sum_l    <= 7'd0;
          sum_r    <= 7'd0;
          idx      <= 3'd0;
        end
        if (acc_step) begin
          sum_l <= sum_l_nxt;
          sum_r <= sum_r_nxt;
          if (idx == 3'd4) begin
            // prod starts at the bare sum: that is the "+1" of (volume+1)
            prod_l <= {3'b000, sum_l_nxt};
            prod_r <= {3'b000, sum_r_nxt};
            idx    <= 3'd0;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        if (mul_step) begin
          prod_l <= prod_l + mul_l_add;
          prod_r <= prod_r + mul_r_add;
          idx    <= idx + 3'd1;
        end
        if (fire) begin
          lout         <= prod_l;
          rout         <= prod_r;
          sample_valid <= 1'b1;
        end
      end
    end
  end

endmodule
